// File: rtl/quad_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : quad_pos_ctrl
// Description : Extends a wrapping quadrature count into an absolute signed
//               position, sequences index homing and flags limit violations.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_pos_ctrl #(
  parameter int CNT_W = 14,
  parameter int POS_W = 32,
  parameter int TO_W  = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             index_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [POS_W-1:0] cmd_data_i,
  input  logic [POS_W-1:0] lim_lo_i,
  input  logic [POS_W-1:0] lim_hi_i,
  output logic [POS_W-1:0] pos_o,
  output logic             busy_o,
  output logic             homed_o,
  output logic             err_o,
  output logic             limit_o
);

  localparam logic [1:0]      c_OP_ZERO   = 2'b00;
  localparam logic [1:0]      c_OP_HOME   = 2'b01;
  localparam logic [1:0]      c_OP_PRESET = 2'b10;
  localparam logic [1:0]      c_OP_ABORT  = 2'b11;
  localparam logic [TO_W-1:0] c_TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SEEK  = 2'b01,
    S_LATCH = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_prime;
  logic [CNT_W-1:0] r_cnt_prev;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] r_offset;
  logic [TO_W-1:0]  r_to;
  logic             r_idx_s1;
  logic             r_idx_s2;
  logic             r_idx_prev;
  logic             r_homed;
  logic             r_err;
  logic             r_limit;

  logic [CNT_W-1:0] w_delta;
  logic [POS_W-1:0] w_pos_ext;
  logic             w_idx_rise;
  logic             w_accept;
  logic             w_to_done;

  // Modular difference reinterpreted as signed handles the count wrap for free.
  assign w_delta     = cnt_i - r_cnt_prev;
  assign w_pos_ext   = r_pos + {{(POS_W-CNT_W){w_delta[CNT_W-1]}}, w_delta};
  assign w_idx_rise  = r_idx_s2 & ~r_idx_prev;
  assign w_to_done   = &r_to;
  assign cmd_ready_o = ~r_prime & (r_state != S_LATCH);
  assign w_accept    = cmd_valid_i & cmd_ready_o;

  assign pos_o   = r_pos;
  assign busy_o  = (r_state == S_SEEK) || (r_state == S_LATCH);
  assign homed_o = r_homed;
  assign err_o   = r_err;
  assign limit_o = r_limit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx_s1   <= 1'b0;
      r_idx_s2   <= 1'b0;
      r_idx_prev <= 1'b0;
    end else begin
      r_idx_s1   <= index_i;
      r_idx_s2   <= r_idx_s1;
      r_idx_prev <= r_idx_s2;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_limit <= 1'b0;
    end else begin
      r_limit <= ($signed(r_pos) < $signed(lim_lo_i)) ||
                 ($signed(r_pos) > $signed(lim_hi_i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_prime    <= 1'b1;
      r_cnt_prev <= '0;
      r_pos      <= '0;
      r_offset   <= '0;
      r_to       <= '0;
      r_homed    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_cnt_prev <= cnt_i;
      if (r_prime) begin
        // First cycle only captures the count reference; position holds.
        r_prime <= 1'b0;
      end else begin
        r_pos <= w_pos_ext;
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              case (cmd_op_i)
                c_OP_ZERO:   r_pos <= '0;
                c_OP_PRESET: r_pos <= cmd_data_i;
                c_OP_HOME: begin
                  r_offset <= cmd_data_i;
                  r_homed  <= 1'b0;
                  r_to     <= '0;
                  r_state  <= S_SEEK;
                end
                c_OP_ABORT:  ;
              endcase
            end
          end
          S_SEEK: begin
            r_to <= r_to + c_TO_ONE;
            if (w_accept && (cmd_op_i != c_OP_ABORT)) begin
              r_err <= 1'b1;
            end
            // Priority: abort, then index, then timeout.
            if (w_accept && (cmd_op_i == c_OP_ABORT)) begin
              r_state <= S_IDLE;
            end else if (w_idx_rise) begin
              r_state <= S_LATCH;
            end else if (w_to_done) begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
            end
          end
          S_LATCH: begin
            r_pos   <= r_offset;
            r_homed <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_pos_ctrl
// Description : Scoreboard bench for quad_pos_ctrl (default and short timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_pos_ctrl;

  localparam logic [1:0] c_ZERO   = 2'b00;
  localparam logic [1:0] c_HOME   = 2'b01;
  localparam logic [1:0] c_PRESET = 2'b10;
  localparam logic [1:0] c_ABORT  = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [13:0] cnt_i;
  logic        index_i;
  logic        cmd_valid_i;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_data_i;
  logic [31:0] lim_lo_i;
  logic [31:0] lim_hi_i;

  logic        cmd_ready_o, busy_o, homed_o, err_o, limit_o;
  logic [31:0] pos_o;
  logic        t_ready, t_busy, t_homed, t_err, t_limit;
  logic [31:0] t_pos;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] pos_q[$];
  logic        lim_q[$];

  always #5 clk_i = ~clk_i;

  quad_pos_ctrl u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_i), .index_i(index_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_data_i(cmd_data_i), .lim_lo_i(lim_lo_i), .lim_hi_i(lim_hi_i),
    .pos_o(pos_o), .busy_o(busy_o), .homed_o(homed_o), .err_o(err_o),
    .limit_o(limit_o)
  );

  quad_pos_ctrl #(.TO_W(4)) u_dut_to (
    .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_i), .index_i(index_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(t_ready), .cmd_op_i(cmd_op_i),
    .cmd_data_i(cmd_data_i), .lim_lo_i(lim_lo_i), .lim_hi_i(lim_hi_i),
    .pos_o(t_pos), .busy_o(t_busy), .homed_o(t_homed), .err_o(t_err),
    .limit_o(t_limit)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the DUTs just past the prime cycle: pos_o=0, reference count = c.
  task automatic apply_reset(input logic [13:0] c);
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = c_ZERO;
    cmd_data_i  = '0;
    index_i     = 1'b0;
    cnt_i       = c;
    #12;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_i = 1'b1; cmd_valid_i = 1'b0; index_i = 1'b0; cnt_i = 14'd100;
    tick(); tick();
    n_total++;
    if ({pos_o, busy_o, homed_o, err_o, limit_o, cmd_ready_o} !== 37'b0)
      $display("FAIL reset_outputs: got pos=%h flags=%b want all zero", pos_o,
               {busy_o, homed_o, err_o, limit_o, cmd_ready_o});
    else n_pass++;
    rst_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_op_i = c_PRESET; cmd_data_i = 32'd77;
    n_total++;
    if (cmd_ready_o !== 1'b0) $display("FAIL prime_ready: got %b want 0", cmd_ready_o);
    else n_pass++;
    tick();
    cmd_valid_i = 1'b0;
    n_total++;
    if (pos_o !== 32'd0) $display("FAIL prime_pos: got %0d want 0", pos_o);
    else n_pass++;
    n_total++;
    if (cmd_ready_o !== 1'b1) $display("FAIL ready_after_prime: got %b want 1", cmd_ready_o);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      cnt_i = 14'(100 + k);
      pos_q.push_back(32'(k));
      tick();
      e = pos_q.pop_front();
      n_total++;
      if (pos_o !== e) $display("FAIL step_pos[%0d]: got %0d want %0d", k, pos_o, e);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [13:0] seq [6];
    int          ex  [6];
    logic [31:0] e;
    seq = '{14'h1FFF, 14'h2000, 14'h2001, 14'h2000, 14'h1FFF, 14'h1FFE};
    ex  = '{1, 2, 3, 2, 1, 0};
    apply_reset(14'h1FFE);
    for (int i = 0; i < 6; i++) begin
      cnt_i = seq[i];
      pos_q.push_back(32'(ex[i]));
      tick();
      e = pos_q.pop_front();
      n_total++;
      if (pos_o !== e) $display("FAIL wrap_pos[%0d]: got %0d want %0d", i, $signed(pos_o), $signed(e));
      else n_pass++;
    end
    apply_reset(14'h0000);
    cnt_i = 14'h3FFF;
    pos_q.push_back(32'hFFFF_FFFF);
    tick();
    e = pos_q.pop_front();
    n_total++;
    if (pos_o !== e) $display("FAIL wrap_neg: got %h want %h", pos_o, e);
    else n_pass++;
  endtask

  task automatic test_preset_zero();
    logic [1:0] op [5];
    logic       vl [5];
    int         ex [5];
    logic [31:0] e;
    op = '{c_ZERO, c_PRESET, c_ZERO, c_ZERO, c_ZERO};
    vl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ex = '{1, 1000, 1001, 0, 1};
    apply_reset(14'd0);
    cmd_data_i = 32'd1000;
    for (int i = 0; i < 5; i++) begin
      cnt_i = 14'(i + 1);
      cmd_valid_i = vl[i];
      cmd_op_i = op[i];
      pos_q.push_back(32'(ex[i]));
      tick();
      e = pos_q.pop_front();
      n_total++;
      if (pos_o !== e) $display("FAIL preset_pos[%0d]: got %0d want %0d", i, pos_o, e);
      else n_pass++;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_home();
    logic [31:0] e;
    logic        eb, eh, ee, er;
    apply_reset(14'd0);
    cnt_i = 14'd1; cmd_valid_i = 1'b1; cmd_op_i = c_HOME; cmd_data_i = 32'(-50);
    tick();
    n_total++;
    if (busy_o !== 1'b1) $display("FAIL home_busy_start: got %b want 1", busy_o);
    else n_pass++;
    for (int i = 1; i <= 25; i++) begin
      cnt_i       = 14'(i + 1);
      cmd_valid_i = (i == 5);
      cmd_op_i    = c_PRESET;
      cmd_data_i  = 32'd999;
      if (i == 21) index_i = 1'b1;
      // Index seen at edge 21, synchronised by 22, LATCH at 23, position at 24.
      if (i <= 23) pos_q.push_back(32'(i + 1));
      else         pos_q.push_back(32'(-50 + (i - 24)));
      tick();
      e  = pos_q.pop_front();
      eb = (i <= 23);
      eh = (i >= 24);
      ee = (i == 5);
      er = (i != 23);
      n_total++;
      if (pos_o !== e) $display("FAIL home_pos[%0d]: got %0d want %0d", i, $signed(pos_o), $signed(e));
      else n_pass++;
      n_total++;
      if ({busy_o, homed_o, err_o, cmd_ready_o} !== {eb, eh, ee, er})
        $display("FAIL home_flags[%0d]: got busy/homed/err/ready=%b want %b", i,
                 {busy_o, homed_o, err_o, cmd_ready_o}, {eb, eh, ee, er});
      else n_pass++;
    end
    index_i = 1'b0;
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset(14'd0);
    cmd_valid_i = 1'b1; cmd_op_i = c_HOME; cmd_data_i = 32'd0;
    tick();
    cmd_valid_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_total++;
      if ({t_err, t_busy} !== {(k == 16), (k < 16)})
        $display("FAIL timeout_flags[%0d]: got err/busy=%b want %b", k,
                 {t_err, t_busy}, {(k == 16), (k < 16)});
      else n_pass++;
    end
    n_total++;
    if (t_homed !== 1'b0) $display("FAIL timeout_homed: got %b want 0", t_homed);
    else n_pass++;
  endtask

  task automatic test_abort();
    apply_reset(14'd0);
    cmd_valid_i = 1'b1; cmd_op_i = c_HOME; cmd_data_i = 32'd5;
    tick();
    cmd_valid_i = 1'b0;
    tick(); tick(); tick();
    cmd_valid_i = 1'b1; cmd_op_i = c_ABORT;
    tick();
    cmd_valid_i = 1'b0;
    n_total++;
    if ({busy_o, err_o} !== 2'b00) $display("FAIL abort_flags: got busy/err=%b want 00", {busy_o, err_o});
    else n_pass++;
    tick();
    n_total++;
    if ({busy_o, err_o, homed_o} !== 3'b000)
      $display("FAIL abort_after: got busy/err/homed=%b want 000", {busy_o, err_o, homed_o});
    else n_pass++;
    // Abort arriving in the same cycle as the index edge must win.
    cmd_valid_i = 1'b1; cmd_op_i = c_HOME;
    tick();
    cmd_valid_i = 1'b0;
    index_i = 1'b1;
    tick(); tick();
    cmd_valid_i = 1'b1; cmd_op_i = c_ABORT;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    n_total++;
    if ({busy_o, homed_o, err_o} !== 3'b000)
      $display("FAIL abort_vs_index: got busy/homed/err=%b want 000", {busy_o, homed_o, err_o});
    else n_pass++;
    index_i = 1'b0;
  endtask

  task automatic test_limits();
    int          v [5];
    logic [31:0] e;
    logic        el;
    v = '{10, 11, -11, -10, 0};
    apply_reset(14'd0);
    lim_lo_i = 32'(-10); lim_hi_i = 32'd10;
    cmd_op_i = c_PRESET;
    for (int i = 0; i <= 5; i++) begin
      cmd_valid_i = (i < 5);
      if (i < 5) begin
        cmd_data_i = 32'(v[i]);
        pos_q.push_back(32'(v[i]));
        lim_q.push_back((v[i] < -10) || (v[i] > 10));
      end
      tick();
      if (i < 5) begin
        e = pos_q.pop_front();
        n_total++;
        if (pos_o !== e) $display("FAIL limit_pos[%0d]: got %0d want %0d", i, $signed(pos_o), $signed(e));
        else n_pass++;
      end
      if (i >= 1) begin
        el = lim_q.pop_front();
        n_total++;
        if (limit_o !== el) $display("FAIL limit_flag[%0d]: got %b want %b", i - 1, limit_o, el);
        else n_pass++;
      end
    end
    cmd_valid_i = 1'b0;
    lim_lo_i = 32'd5; lim_hi_i = 32'(-5);
    tick();
    n_total++;
    if (limit_o !== 1'b1) $display("FAIL limit_inverted: got %b want 1", limit_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset(14'd0);
    lim_lo_i = 32'(-10); lim_hi_i = 32'd10;
    cmd_valid_i = 1'b1; cmd_op_i = c_PRESET; cmd_data_i = 32'd123;
    tick();
    cmd_op_i = c_HOME; cmd_data_i = 32'd0;
    tick();
    cmd_valid_i = 1'b0;
    n_total++;
    if ({busy_o, limit_o} !== 2'b11) $display("FAIL pre_reset_state: got busy/limit=%b want 11", {busy_o, limit_o});
    else n_pass++;
    #1;
    rst_i = 1'b1;
    #1;
    n_total++;
    if ({pos_o, busy_o, homed_o, err_o, limit_o, cmd_ready_o} !== 37'b0)
      $display("FAIL async_reset: got pos=%h flags=%b want all zero", pos_o,
               {busy_o, homed_o, err_o, limit_o, cmd_ready_o});
    else n_pass++;
    tick();
    n_total++;
    if (err_o !== 1'b0) $display("FAIL async_reset_err: got %b want 0", err_o);
    else n_pass++;
  endtask

  initial begin
    rst_i = 1'b1; cnt_i = '0; index_i = 1'b0; cmd_valid_i = 1'b0;
    cmd_op_i = c_ZERO; cmd_data_i = '0;
    lim_lo_i = 32'(-1000000); lim_hi_i = 32'd1000000;
    test_reset();
    test_wrap();
    test_preset_zero();
    test_home();
    test_timeout();
    test_abort();
    test_limits();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
